// File: rtl/light_pkg.sv
// Shared types and helpers for the light dimmer: FSM state encoding and the
// level-to-duty mapping.
package light_pkg;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } state_e;

    // The 64-bit product is exact: level < 2^LW and pwm_max < 2^PWM_BITS.
    function automatic logic [63:0] duty_of_level(
        input logic [63:0] level,
        input logic [63:0] pwm_max,
        input logic [63:0] max_level
    );
        return (level * pwm_max) / max_level;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchroniser, stability debouncer and a one-cycle
// pulse on the accepted press edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [2:0]    vld_q;
    logic          last_q;
    logic          deb_q;
    logic          armed_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable;

    // cnt_d is (cycles the synchronised level has been held) - 1, saturating.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (!vld_q[2] || (sync_q[1] != last_q)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
        stable = vld_q[1] && (cnt_d == CNT_LAST);
    end

    // A press is only reported once a stable release has been seen, so a
    // button held through reset never produces a pulse.
    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples the pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q  <= '0;
            vld_q   <= '0;
            last_q  <= 1'b0;
            deb_q   <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], i_raw};
            vld_q   <= {vld_q[1:0], 1'b1};
            last_q  <= sync_q[1];
            cnt_q   <= cnt_d;
            pulse_q <= 1'b0;
            if (stable) begin
                if (sync_q[1] != deb_q) begin
                    deb_q   <= sync_q[1];
                    pulse_q <= sync_q[1] & armed_q;
                end
                if (!sync_q[1]) begin
                    armed_q <= 1'b1;
                end
            end
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/light_dimmer.sv
// Three-button LED dimmer: OFF/ON level FSM, linear duty fade and a
// glitch-free PWM output stage.
module light_dimmer
    import light_pkg::*;
#(
    parameter int PWM_BITS   = 10,
    parameter int LEVELS     = 8,
    parameter int PRESCALE   = 100,
    parameter int FADE_DIV   = 1000,
    parameter int FADE_STEP  = 4,
    parameter int DEB_CYCLES = 100000,
    localparam int LW        = $clog2(LEVELS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [2:0]    i_button,
    output logic          o_light_led,
    output logic [LW-1:0] o_level,
    output logic          o_busy
);

    localparam int PWM_MAX   = (1 << PWM_BITS) - 1;
    localparam int MAX_LEVEL = LEVELS - 1;
    localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW        = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic up_p, down_p, power_p;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
        .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_button[0]), .o_pulse(up_p)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down (
        .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_button[1]), .o_pulse(down_p)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_power (
        .i_clk(i_clk), .i_reset(i_reset), .i_raw(i_button[2]), .o_pulse(power_p)
    );

    state_e        state_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] saved_q;

    // Priority power > up > down; lower-priority pulses in the same cycle are dropped.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= OFF;
            level_q <= '0;
            saved_q <= LW'(1);
        end else begin
            case (state_q)
                OFF: begin
                    if (power_p || up_p) begin
                        state_q <= ON;
                        level_q <= saved_q;
                    end
                end
                ON: begin
                    if (power_p) begin
                        state_q <= OFF;
                        saved_q <= level_q;
                        level_q <= '0;
                    end else if (up_p) begin
                        if (level_q != LW'(MAX_LEVEL)) begin
                            level_q <= level_q + LW'(1);
                        end
                    end else if (down_p) begin
                        if (level_q == LW'(1)) begin
                            state_q <= OFF;
                            saved_q <= LW'(1);
                            level_q <= '0;
                        end else begin
                            level_q <= level_q - LW'(1);
                        end
                    end
                end
                default: state_q <= OFF;
            endcase
        end
    end

    logic [PWM_BITS-1:0] target;
    assign target = (state_q == ON)
        ? PWM_BITS'(duty_of_level(64'(level_q), 64'(PWM_MAX), 64'(MAX_LEVEL)))
        : '0;

    logic [FW-1:0]       fdiv_q;
    logic [PW-1:0]       pre_q;
    logic [PWM_BITS-1:0] fade_q, fade_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS-1:0] applied_q;
    logic                led_q;
    logic                busy_q;
    logic                fade_tick;
    logic                pwm_tick;
    int                  gap;

    assign fade_tick = (fdiv_q == FW'(FADE_DIV - 1));
    assign pwm_tick  = (pre_q == PW'(PRESCALE - 1));

    // Fade always starts from the current fade duty, so a new target simply redirects it.
    always_comb begin
        fade_d = fade_q;
        gap    = int'(target) - int'(fade_q);
        if (fade_tick) begin
            if (gap > FADE_STEP) begin
                fade_d = fade_q + PWM_BITS'(FADE_STEP);
            end else if (gap < -FADE_STEP) begin
                fade_d = fade_q - PWM_BITS'(FADE_STEP);
            end else begin
                fade_d = target;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fdiv_q    <= '0;
            pre_q     <= '0;
            fade_q    <= '0;
            pwm_q     <= '0;
            applied_q <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            fdiv_q <= fade_tick ? '0 : fdiv_q + FW'(1);
            pre_q  <= pwm_tick ? '0 : pre_q + PW'(1);
            fade_q <= fade_d;
            if (pwm_tick) begin
                pwm_q <= pwm_q + PWM_BITS'(1);
                // Compare value only changes at a period boundary.
                if (pwm_q == PWM_BITS'(PWM_MAX)) begin
                    applied_q <= fade_q;
                end
            end
            led_q  <= (pwm_q < applied_q) || (applied_q == PWM_BITS'(PWM_MAX));
            busy_q <= (applied_q != target);
        end
    end

    assign o_light_led = led_q;
    assign o_level     = level_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_light_dimmer.sv
// Directed bench for light_dimmer with small parameters: level FSM, fade,
// PWM duty, debounce rejection and reset behaviour.
module tb_light_dimmer;

    localparam int PWM_BITS   = 4;
    localparam int LEVELS     = 5;
    localparam int PRESCALE   = 1;
    localparam int FADE_DIV   = 2;
    localparam int FADE_STEP  = 3;
    localparam int DEB_CYCLES = 4;

    localparam logic [2:0] UP   = 3'b001;
    localparam logic [2:0] DOWN = 3'b010;
    localparam logic [2:0] PWR  = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] btn;
    logic       led;
    logic [2:0] level;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    light_dimmer #(
        .PWM_BITS(PWM_BITS), .LEVELS(LEVELS), .PRESCALE(PRESCALE),
        .FADE_DIV(FADE_DIV), .FADE_STEP(FADE_STEP), .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_button(btn),
        .o_light_led(led),
        .o_level(level),
        .o_busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold the given buttons, release, and report how often o_level changed.
    task automatic press(input logic [2:0] b, input int hold, output int changes,
                         output logic saw_busy);
        logic [2:0] prev;
        prev     = level;
        changes  = 0;
        saw_busy = 1'b0;
        btn      = b;
        for (int i = 0; i < hold + 8; i++) begin
            if (i == hold) btn = 3'b000;
            @(negedge clk);
            if (level !== prev) changes++;
            if (busy === 1'b1) saw_busy = 1'b1;
            prev = level;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic measure(output int highs);
        highs = 0;
        repeat (16) begin
            @(negedge clk);
            if (led === 1'b1) highs++;
        end
    endtask

    initial begin
        int   changes;
        int   highs;
        int   n;
        logic saw_busy;
        int   up_exp [5];
        up_exp = '{2, 3, 4, 4, 4};

        rst_n = 1'b0;
        btn   = 3'b000;
        repeat (3) @(negedge clk);
        check("reset_level", 32'(level), 32'd0);
        check("reset_led", 32'(led), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Power from OFF: one pulse, level 1, duty 3/16.
        press(PWR, 10, changes, saw_busy);
        check("pwr_one_pulse", 32'(changes), 32'd1);
        check("pwr_level", 32'(level), 32'd1);
        check("pwr_busy_seen", 32'(saw_busy), 32'd1);
        wait_idle("pwr_idle");
        measure(highs);
        check("pwr_duty", 32'(highs), 32'd3);

        // Up five times saturates at level 4, full-on output.
        for (int i = 0; i < 5; i++) begin
            press(UP, 10, changes, saw_busy);
            check($sformatf("up%0d_level", i), 32'(level), 32'(up_exp[i]));
        end
        wait_idle("max_idle");
        measure(highs);
        check("max_duty", 32'(highs), 32'd16);

        // Walk down to OFF, checking intermediate duties.
        press(DOWN, 10, changes, saw_busy);
        check("dn_l3_level", 32'(level), 32'd3);
        wait_idle("l3_idle");
        measure(highs);
        check("l3_duty", 32'(highs), 32'd11);
        press(DOWN, 10, changes, saw_busy);
        check("dn_l2_level", 32'(level), 32'd2);
        wait_idle("l2_idle");
        measure(highs);
        check("l2_duty", 32'(highs), 32'd7);
        press(DOWN, 10, changes, saw_busy);
        check("dn_l1_level", 32'(level), 32'd1);
        press(DOWN, 10, changes, saw_busy);
        check("dn_off_level", 32'(level), 32'd0);
        wait_idle("off_idle");
        measure(highs);
        check("off_duty", 32'(highs), 32'd0);
        press(PWR, 10, changes, saw_busy);
        check("pwr_saved1_level", 32'(level), 32'd1);

        // Power and up together from level 3: power wins, level 3 saved.
        press(UP, 10, changes, saw_busy);
        press(UP, 10, changes, saw_busy);
        check("prio_pre_level", 32'(level), 32'd3);
        press(PWR | UP, 10, changes, saw_busy);
        check("prio_level", 32'(level), 32'd0);
        check("prio_changes", 32'(changes), 32'd1);
        press(DOWN, 10, changes, saw_busy);
        check("off_down_ignored", 32'(level), 32'd0);
        press(UP, 10, changes, saw_busy);
        check("up_saved3_level", 32'(level), 32'd3);
        wait_idle("l3b_idle");
        measure(highs);
        check("l3b_duty", 32'(highs), 32'd11);

        // Three-cycle glitches are shorter than the debounce window.
        repeat (3) begin
            btn = UP;
            repeat (3) @(negedge clk);
            btn = 3'b000;
            repeat (3) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("glitch_level", 32'(level), 32'd3);

        // Back to level 1, then reset mid-fade toward level 2 with up held.
        press(DOWN, 10, changes, saw_busy);
        press(DOWN, 10, changes, saw_busy);
        check("l1_again_level", 32'(level), 32'd1);
        wait_idle("l1_idle");
        btn = UP;
        n = 0;
        while (level !== 3'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fade_up_level", 32'(level), 32'd2);
        @(negedge clk);
        check("midfade_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        changes = 0;
        repeat (20) begin
            @(negedge clk);
            if (level !== 3'd0) changes++;
        end
        check("held_no_pulse", 32'(changes), 32'd0);
        btn = 3'b000;
        repeat (8) @(negedge clk);
        press(PWR, 10, changes, saw_busy);
        check("post_rst_level", 32'(level), 32'd1);
        wait_idle("post_rst_idle");
        measure(highs);
        check("post_rst_duty", 32'(highs), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_dimmer.md
LIGHT_DIMMER -- requirements
Module: light_dimmer

Interface
REQ-001 SHALL have parameter PWM_BITS, default 10, PWM counter width; PWM_MAX = 2^PWM_BITS-1.
REQ-002 SHALL have parameter LEVELS, default 8, number of brightness levels including 0; range 2..256; LW = clog2(LEVELS).
REQ-003 SHALL have parameter PRESCALE, default 100, i_clk cycles per PWM counter step; PRESCALE >= 1.
REQ-004 SHALL have parameter FADE_DIV, default 1000, i_clk cycles per fade step.
REQ-005 SHALL have parameter FADE_STEP, default 4, duty change per fade step.
REQ-006 SHALL have parameter DEB_CYCLES, default 100000, cycles a raw button must be stable to be accepted.
REQ-007 SHALL have port i_clk, input, 1, single system clock, all logic rising-edge.
REQ-008 SHALL have port i_reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port i_button, input, 3, raw buttons: [0] up, [1] down, [2] power; asynchronous to i_clk.
REQ-010 SHALL have port o_light_led, output, 1, PWM drive.
REQ-011 SHALL have port o_level, output, LW, committed level; 0 when OFF.
REQ-012 SHALL have port o_busy, output, 1, high while the applied duty differs from the target duty.

Function
REQ-013 Each button SHALL be 2-flop synchronised, debounced over DEB_CYCLES stable cycles, and produce a one-cycle pulse on the debounced rising edge only.
REQ-014 FSM states SHALL be OFF and ON; a register saved_level (reset 1) SHALL hold the last ON level.
REQ-015 In OFF, a power or up pulse SHALL go to ON with level = saved_level; a down pulse SHALL be ignored.
REQ-016 In ON, up SHALL set level+1, saturating at LEVELS-1; down SHALL set level-1; down at level 1 SHALL go to OFF with saved_level = 1.
REQ-017 In ON, power SHALL go to OFF and copy level to saved_level.
REQ-018 Pulses arriving in the same cycle SHALL be resolved power > up > down; lower-priority pulses that cycle SHALL be discarded.
REQ-019 Target duty SHALL be (level * PWM_MAX) / (LEVELS-1), integer truncation, with intermediate width PWM_BITS+LW; target is 0 in OFF.
REQ-020 Every FADE_DIV cycles, the fade duty SHALL move toward the target by FADE_STEP, clamped to the target with no overshoot.
REQ-021 The PWM counter SHALL advance once per PRESCALE cycles and wrap from PWM_MAX to 0.
REQ-022 The applied compare value SHALL load from the fade duty only on the step where the counter wraps to 0, so no period is glitched.
REQ-023 o_light_led SHALL be (counter < applied) OR (applied == PWM_MAX), registered (one-cycle latency), so level 0 gives constant 0 and the max level gives constant 1.
REQ-024 o_level SHALL update the cycle after the accepted pulse.
REQ-025 o_busy SHALL equal (applied != target), registered.
REQ-026 A target change mid-fade SHALL redirect the fade from the current fade duty with no restart.

Reset
REQ-027 Asserting i_reset SHALL immediately clear the state to OFF, all counters to 0, fade and applied duty to 0, debouncers to released, saved_level to 1, o_light_led 0, o_level 0 and o_busy 0.
REQ-028 Reset applied mid-fade or mid-debounce SHALL discard all progress; after deassertion no pulse is produced by a button already held.

Structure
REQ-029 Shared package light_pkg SHALL hold the FSM state enum (OFF, ON) and a duty_of_level function.
REQ-030 Debounce plus edge detect SHALL be sub-module btn_debounce, instantiated three times; the prescaler, PWM, fade and FSM logic SHALL live in light_dimmer.

Verification
All scenarios use PWM_BITS=4, LEVELS=5, PRESCALE=1, FADE_DIV=2, FADE_STEP=3, DEB_CYCLES=4.
REQ-031 Power press held 10 cycles from OFF -> exactly one pulse; o_level=1; target 3; duty ramps to 3; o_busy falls.
REQ-032 Up pressed 5 times from level 1 -> o_level 2,3,4,4,4; final target 15; o_light_led constant 1 after settling.
REQ-033 From level 2, down twice -> o_level 1 then 0; OFF; output constant 0 after the fade; then power -> o_level=1 (saved_level 1).
REQ-034 Power and up pulses in the same cycle from level 3 -> OFF; saved_level=3; next up -> o_level=3.
REQ-035 Button bouncing 3-cycle glitches -> no pulse; o_level unchanged.
REQ-036 i_reset asserted mid-fade at duty 6 -> all outputs 0 at once; held button after release -> no pulse.
